// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger arming block: FSM states, edge-select codes
// and the event qualification helper.
package trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_RISE  = 2'b00;
    localparam logic [1:0] SEL_FALL  = 2'b01;
    localparam logic [1:0] SEL_BOTH  = 2'b10;
    localparam logic [1:0] SEL_LEVEL = 2'b11;

    function automatic logic event_hit(
        input logic [1:0] sel,
        input logic       rise,
        input logic       fall,
        input logic       level
    );
        logic hit;
        case (sel)
            SEL_RISE: hit = rise;
            SEL_FALL: hit = fall;
            SEL_BOTH: hit = rise | fall;
            default:  hit = level;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop; edge and level flags are registered so
// the arming FSM sees a change three edges after it was first sampled.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            level <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= sync2;
            rise  <= sync2 & ~hist;
            fall  <= ~sync2 & hist;
            level <= sync2;
        end
    end

endmodule

// File: rtl/trigger_arm.sv
// Arms on request, counts qualifying external events and fires a one-cycle start
// pulse to a downstream trigger, with optional timeout and abort.
module trigger_arm
    import trigger_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TMO_W = 32
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_ARM,
    input  logic             i_DISARM,
    input  logic             i_EXT_TRIG,
    input  logic [1:0]       i_EDGE_SEL,
    input  logic [CNT_W-1:0] i_EDGE_COUNT,
    input  logic [TMO_W-1:0] i_TIMEOUT,
    input  logic             i_TRIG_DONE,
    output logic             o_EN,
    output logic             o_ARMED,
    output logic             o_BUSY,
    output logic             o_FIRED,
    output logic             o_TIMEDOUT,
    output logic [CNT_W-1:0] o_EDGE_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] count_q;
    logic [TMO_W-1:0] timeout_q;
    logic [CNT_W-1:0] edge_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             en;
    logic             fired;
    logic             timedout;

    logic             rise;
    logic             fall;
    logic             level;
    logic             hit;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt_inc;
    logic [TMO_W-1:0] tmo_inc;
    logic             fire;
    logic             expire;

    sync_edge_detect u_sync (
        .clk   (i_CLK),
        .rst_n (i_RST_N),
        .din   (i_EXT_TRIG),
        .rise  (rise),
        .fall  (fall),
        .level (level)
    );

    assign hit     = event_hit(sel_q, rise, fall, level);
    assign target  = (count_q == '0) ? CNT_ONE : count_q;
    assign cnt_inc = (edge_cnt == '1) ? edge_cnt : edge_cnt + CNT_ONE;
    assign tmo_inc = tmo_cnt + TMO_ONE;
    assign fire    = hit && (cnt_inc >= target);
    // Firing is evaluated first, so a coincident expiry never suppresses the pulse.
    assign expire  = (timeout_q != '0) && (tmo_inc == timeout_q);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state     <= ST_IDLE;
            sel_q     <= 2'b00;
            count_q   <= '0;
            timeout_q <= '0;
            edge_cnt  <= '0;
            tmo_cnt   <= '0;
            en        <= 1'b0;
            fired     <= 1'b0;
            timedout  <= 1'b0;
        end else begin
            en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_ARM && !i_DISARM) begin
                        sel_q     <= i_EDGE_SEL;
                        count_q   <= i_EDGE_COUNT;
                        timeout_q <= i_TIMEOUT;
                        edge_cnt  <= '0;
                        tmo_cnt   <= '0;
                        fired     <= 1'b0;
                        timedout  <= 1'b0;
                        state     <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (i_DISARM) begin
                        state <= ST_IDLE;
                    end else begin
                        if (hit) begin
                            edge_cnt <= cnt_inc;
                        end
                        if (fire) begin
                            en    <= 1'b1;
                            state <= ST_WAIT_DONE;
                        end else begin
                            tmo_cnt <= tmo_inc;
                            if (expire) begin
                                timedout <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_DISARM) begin
                        state <= ST_IDLE;
                    end else if (i_TRIG_DONE) begin
                        fired <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_EN       = en;
    assign o_ARMED    = (state == ST_ARMED);
    assign o_BUSY     = (state != ST_IDLE);
    assign o_FIRED    = fired;
    assign o_TIMEDOUT = timedout;
    assign o_EDGE_CNT = edge_cnt;

endmodule

// File: tb/tb_trigger_arm.sv
// Directed and randomized checks of trigger_arm against an event-level reference model.
module tb_trigger_arm;

    localparam int CNT_W = 16;
    localparam int TMO_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arm;
    logic             disarm;
    logic             ext;
    logic [1:0]       edge_sel;
    logic [CNT_W-1:0] edge_count;
    logic [TMO_W-1:0] timeout;
    logic             trig_done;
    logic             en;
    logic             armed;
    logic             busy;
    logic             fired;
    logic             timedout;
    logic [CNT_W-1:0] edge_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: external samples seen since reset plus arm status
    bit ext_q[$];
    bit m_armed, m_wait, m_en, m_fired, m_to;
    int m_sel, m_target, m_tmo, m_cnt, m_tc;

    always #5 clk = ~clk;

    trigger_arm #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_ARM        (arm),
        .i_DISARM     (disarm),
        .i_EXT_TRIG   (ext),
        .i_EDGE_SEL   (edge_sel),
        .i_EDGE_COUNT (edge_count),
        .i_TIMEOUT    (timeout),
        .i_TRIG_DONE  (trig_done),
        .o_EN         (en),
        .o_ARMED      (armed),
        .o_BUSY       (busy),
        .o_FIRED      (fired),
        .o_TIMEDOUT   (timedout),
        .o_EDGE_CNT   (edge_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit past(input int d);
        int i;
        i = ext_q.size() - 1 - d;
        return (i >= 0) ? ext_q[i] : 1'b0;
    endfunction

    task automatic model_clear();
        ext_q.delete();
        m_armed = 0; m_wait = 0; m_en = 0; m_fired = 0; m_to = 0;
        m_sel = 0; m_target = 0; m_tmo = 0; m_cnt = 0; m_tc = 0;
    endtask

    // An external change sampled at edge n is acted on at edge n+3.
    task automatic model_edge();
        bit e3, e4, ev;
        int tgt;
        ext_q.push_back(ext);
        if (ext_q.size() > 8) ext_q.delete(0);
        e3 = past(3);
        e4 = past(4);
        case (m_sel)
            0:       ev = e3 && !e4;
            1:       ev = !e3 && e4;
            2:       ev = e3 != e4;
            default: ev = e3;
        endcase
        m_en = 0;
        if (m_wait) begin
            if (disarm) m_wait = 0;
            else if (trig_done) begin m_fired = 1; m_wait = 0; end
        end else if (m_armed) begin
            if (disarm) m_armed = 0;
            else begin
                if (ev && m_cnt < 65535) m_cnt++;
                tgt = (m_target == 0) ? 1 : m_target;
                if (ev && m_cnt >= tgt) begin
                    m_en = 1; m_armed = 0; m_wait = 1;
                end else begin
                    m_tc++;
                    if (m_tmo != 0 && m_tc == m_tmo) begin m_to = 1; m_armed = 0; end
                end
            end
        end else if (arm && !disarm) begin
            m_sel = int'(edge_sel); m_target = int'(edge_count); m_tmo = int'(timeout);
            m_cnt = 0; m_tc = 0; m_fired = 0; m_to = 0; m_armed = 1;
        end
    endtask

    task automatic check_all();
        chk("en", en, m_en);
        chk("armed", armed, m_armed);
        chk("busy", busy, m_armed || m_wait);
        chk("fired", fired, m_fired);
        chk("timedout", timedout, m_to);
        chk("edge_cnt", edge_cnt, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en"}, en, 0);
        chk({tag, "_armed"}, armed, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fired"}, fired, 0);
        chk({tag, "_timedout"}, timedout, 0);
        chk({tag, "_edge_cnt"}, edge_cnt, 0);
    endtask

    task automatic mid_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_clear();
        arm = 0; disarm = 0; trig_done = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic arm_with(input logic [1:0] s, input int c, input int t);
        edge_sel = s; edge_count = CNT_W'(c); timeout = TMO_W'(t);
        arm = 1; step(); arm = 0;
    endtask

    initial begin
        int first, hits, hit_at, to_at, ens;
        rst_n = 0; arm = 0; disarm = 0; ext = 1; trig_done = 0;
        edge_sel = 0; edge_count = 0; timeout = 0;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset");
        rst_n = 1;

        // Level held high through reset: first event only reaches the FSM at edge 4
        first = 0;
        arm_with(2'b11, 1, 0);
        for (int i = 2; i <= 6; i++) begin
            step();
            if (en && first == 0) first = i;
        end
        chk("t0_first_en", first, 4);
        trig_done = 1; step(); trig_done = 0;
        ext = 0; repeat (6) step();

        // Rising edge, count 1: o_EN in the cycle after edge k+3
        arm_with(2'b00, 1, 0);
        repeat (4) step();
        ext = 1; step(); step(); step();
        chk("t1_en_early", en, 0);
        step();
        chk("t1_en_k3", en, 1);
        step();
        chk("t1_en_once", en, 0);
        chk("t1_cnt", edge_cnt, 1);
        trig_done = 1; step(); trig_done = 0;
        chk("t1_fired", fired, 1);
        chk("t1_idle", busy, 0);

        // Both edges, count 4
        arm_with(2'b10, 4, 0);
        repeat (3) step();
        hits = 0; hit_at = -1;
        for (int t = 0; t < 4; t++) begin
            ext = ~ext;
            for (int j = 0; j < 5; j++) begin
                step();
                if (en) begin hits++; hit_at = t * 5 + j; end
            end
        end
        chk("t2_hits", hits, 1);
        chk("t2_hit_at", hit_at, 18);
        chk("t2_cnt", edge_cnt, 4);
        trig_done = 1; step(); trig_done = 0;

        // Timeout of 20 with only two of three edges
        ext = 0; repeat (5) step();
        arm_with(2'b00, 3, 20);
        to_at = -1; ens = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3 || i == 9) ext = 1;
            if (i == 6) ext = 0;
            step();
            if (timedout && to_at < 0) to_at = i;
            if (en) ens++;
        end
        chk("t3_to_at", to_at, 20);
        chk("t3_no_en", ens, 0);
        chk("t3_idle", busy, 0);
        chk("t3_cnt", edge_cnt, 2);

        // Disarm before any edge
        ext = 0; repeat (5) step();
        arm_with(2'b00, 1, 0);
        disarm = 1; step(); disarm = 0;
        ens = 0;
        repeat (4) begin
            ext = 1; repeat (3) begin step(); if (en) ens++; end
            ext = 0; repeat (3) begin step(); if (en) ens++; end
        end
        chk("t4_no_en", ens, 0);
        chk("t4_fired", fired, 0);
        chk("t4_timedout", timedout, 0);
        chk("t4_armed", armed, 0);

        // Arm ignored in WAIT_DONE, done ignored in IDLE
        repeat (3) step();
        arm_with(2'b00, 1, 0);
        ext = 1; repeat (5) step();
        chk("t5_wait", busy, 1);
        edge_sel = 2'b11; edge_count = 7; timeout = 5;
        arm = 1; step(); arm = 0;
        chk("t5_arm_ignored_busy", busy, 1);
        chk("t5_arm_ignored_armed", armed, 0);
        repeat (8) step();
        chk("t5_still_wait", busy, 1);
        trig_done = 1; step(); trig_done = 0;
        chk("t5_fired", fired, 1);
        trig_done = 1; step(); trig_done = 0;
        chk("t5_done_idle_fired", fired, 1);
        chk("t5_done_idle_busy", busy, 0);

        // Arm while ARMED must not replace the latched configuration
        ext = 0; repeat (5) step();
        arm_with(2'b00, 2, 0);
        step();
        edge_sel = 2'b11; edge_count = 1; timeout = 3;
        arm = 1; step(); arm = 0;
        ext = 1; ens = 0;
        repeat (8) begin step(); if (en) ens++; end
        chk("t5b_no_en", ens, 0);
        chk("t5b_cnt", edge_cnt, 1);
        chk("t5b_armed", armed, 1);
        ext = 0; repeat (3) step();
        ext = 1; repeat (5) step();
        chk("t5b_wait", busy, 1);
        disarm = 1; step(); disarm = 0;
        chk("t5b_disarm_busy", busy, 0);
        chk("t5b_disarm_fired", fired, 0);

        // Reset mid-ARMED with two counted edges
        ext = 0; repeat (5) step();
        arm_with(2'b00, 5, 0);
        repeat (2) begin
            ext = 1; repeat (4) step();
            ext = 0; repeat (4) step();
        end
        chk("t6_cnt_before", edge_cnt, 2);
        mid_reset();
        arm_with(2'b00, 5, 0);
        chk("t6_cnt_restart", edge_cnt, 0);
        chk("t6_armed", armed, 1);
        ext = 1; repeat (5) step();
        chk("t6_cnt_one", edge_cnt, 1);
        disarm = 1; step(); disarm = 0;

        // Firing and timeout expiry on the same edge
        repeat (5) step();
        arm_with(2'b11, 10, 10);
        hit_at = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (en) hit_at = i;
        end
        chk("t7_en_at", hit_at, 10);
        chk("t7_timedout", timedout, 0);
        chk("t7_wait", busy, 1);
        trig_done = 1; step(); trig_done = 0;

        // Disarm coinciding with the firing event
        arm_with(2'b11, 3, 0);
        step(); step();
        disarm = 1; step(); disarm = 0;
        chk("t8_en", en, 0);
        chk("t8_busy", busy, 0);
        ens = 0;
        repeat (4) begin step(); if (en) ens++; end
        chk("t8_silent", ens, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) mid_reset();
            if ($urandom_range(5) == 0) ext = ~ext;
            arm = 0; disarm = 0; trig_done = 0;
            if (!(m_armed || m_wait)) begin
                if ($urandom_range(7) == 0) arm = 1;
            end else if ($urandom_range(29) == 0) begin
                arm = 1;
            end
            if (arm) begin
                edge_sel = 2'($urandom_range(3));
                edge_count = CNT_W'($urandom_range(4));
                timeout = ($urandom_range(2) == 0) ? '0 : TMO_W'($urandom_range(40, 5));
            end
            if ($urandom_range(59) == 0) disarm = 1;
            if ($urandom_range(4) == 0) trig_done = 1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trigger_arm.md
TRIGGER_ARM -- requirements
Module: trigger_arm

Interface
REQ-001 Parameter CNT_W, default 16, width of the edge-count configuration and status.
REQ-002 Parameter TMO_W, default 32, width of the arm timeout configuration.
REQ-003 i_CLK  in  1  sole clock; all logic is on its rising edge.
REQ-004 i_RST_N  in  1  asynchronous reset, active-low.
REQ-005 i_ARM  in  1  single-cycle arm request.
REQ-006 i_DISARM  in  1  single-cycle abort request.
REQ-007 i_EXT_TRIG  in  1  asynchronous target signal.
REQ-008 i_EDGE_SEL  in  2  00 rising, 01 falling, 10 both edges, 11 high level.
REQ-009 i_EDGE_COUNT  in  CNT_W  qualifying event number to fire on; 0 is treated as 1.
REQ-010 i_TIMEOUT  in  TMO_W  maximum ARMED cycles; 0 disables the timeout.
REQ-011 i_TRIG_DONE  in  1  completion pulse from the downstream trigger (its o_DONE).
REQ-012 o_EN  out  1  single-cycle start pulse to the downstream trigger (its i_EN).
REQ-013 o_ARMED  out  1  high while in ARMED.
REQ-014 o_BUSY  out  1  high in ARMED or WAIT_DONE.
REQ-015 o_FIRED  out  1  sticky: last arm ended by firing and completing.
REQ-016 o_TIMEDOUT  out  1  sticky: last arm ended by timeout.
REQ-017 o_EDGE_CNT  out  CNT_W  qualifying events counted since the last arm; saturates at all-ones.

Function
REQ-018 The FSM SHALL have three states: IDLE, ARMED and WAIT_DONE.
REQ-019 In IDLE, i_ARM SHALL latch i_EDGE_SEL, i_EDGE_COUNT and i_TIMEOUT, clear o_EDGE_CNT, o_FIRED and o_TIMEDOUT and the timeout counter, and enter ARMED on the next edge.
REQ-020 Outside IDLE, i_ARM SHALL be ignored and SHALL NOT alter the latched configuration.
REQ-021 i_EXT_TRIG SHALL pass through a two-flop synchronizer, followed by one history flop used for edge detection.
REQ-022 Edge latency: a level change first sampled at edge k SHALL produce o_EN high for exactly the cycle following edge k+3, provided it is the firing event.
REQ-023 Only events detected while in ARMED SHALL increment o_EDGE_CNT; edges present in the pipeline at arm time but detected in IDLE SHALL NOT count.
REQ-024 Level mode (11) SHALL count one event per cycle in which the synchronized level is high while ARMED.
REQ-025 When the event count reaches the latched count (0 treated as 1), the block SHALL pulse o_EN for one cycle and enter WAIT_DONE.
REQ-026 In WAIT_DONE, i_TRIG_DONE SHALL set o_FIRED and return the FSM to IDLE; further events SHALL be ignored.
REQ-027 When the latched timeout is nonzero, the ARMED cycle counter SHALL reach that value, then set o_TIMEDOUT and return to IDLE without pulsing o_EN.
REQ-028 If a firing event and timeout expiry coincide, the firing event SHALL win.
REQ-029 i_DISARM in ARMED or WAIT_DONE SHALL return the FSM to IDLE with no o_EN pulse and no change to the sticky flags.
REQ-030 If i_DISARM and i_ARM coincide in IDLE, the block SHALL stay in IDLE.
REQ-031 If i_DISARM coincides with a firing event, the block SHALL stay silent: no o_EN pulse.
REQ-032 i_TRIG_DONE outside WAIT_DONE SHALL be ignored.

Reset
REQ-033 Asserting i_RST_N low SHALL immediately force the FSM to IDLE and clear all outputs, synchronizer flops, counters and latched configuration to 0, including during ARMED or WAIT_DONE.
REQ-034 For the first three cycles after reset release, no edge SHALL be reported, since the synchronizer history is 0.

Structure
REQ-035 The state encoding and the EDGE_SEL code constants SHALL live in the shared package trigger_pkg.
REQ-036 Synchronizer plus edge and level detection SHALL be the sub-module sync_edge_detect, with outputs rise, fall and level.

Verification
REQ-037 Arm with SEL=00, COUNT=1, TIMEOUT=0; raise EXT at edge k -> o_EN high only in cycle k+3; o_FIRED set after the i_TRIG_DONE pulse.
REQ-038 Arm with SEL=10, COUNT=4; toggle EXT 4 times, 5 cycles apart -> o_EN on the 4th toggle only; o_EDGE_CNT=4.
REQ-039 Arm with COUNT=3, TIMEOUT=20; give 2 edges -> o_TIMEDOUT set 20 cycles after ARMED entry; no o_EN; FSM in IDLE.
REQ-040 Arm, then i_DISARM before any edge; later edges -> no o_EN; o_FIRED and o_TIMEDOUT stay 0.
REQ-041 Pulse i_ARM during WAIT_DONE and pulse i_TRIG_DONE in IDLE -> both ignored; the configuration is unchanged.
REQ-042 Assert reset mid-ARMED with o_EDGE_CNT=2 -> all outputs 0 immediately; a later arm restarts the count from 0.
